// File: rtl/i_cache_if.sv
// Bus bundles for the instruction cache: fetch side and instruction-memory side.
// The fetch stage is the master of the fetch bundle; the cache is the master
// of the memory bundle.

interface i_cache_fetch_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDRESS_WIDTH     = 32
);
  logic                         cpu_read;
  logic [ADDRESS_WIDTH-1:0]     pc;
  logic                         flush;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         cpu_busywait;

  modport master (output cpu_read, pc, flush, input instruction, cpu_busywait);
  modport slave  (input cpu_read, pc, flush, output instruction, cpu_busywait);
endinterface

interface i_cache_mem_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDRESS_WIDTH     = 32
);
  logic                           mem_read;
  logic [ADDRESS_WIDTH-5:0]       mem_address;
  logic [4*INSTRUCTION_WIDTH-1:0] mem_readdata;
  logic                           mem_busywait;

  modport master (output mem_read, mem_address, input mem_readdata, mem_busywait);
  modport slave  (input mem_read, mem_address, output mem_readdata, mem_busywait);
endinterface

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: 2^INDEX_BITS lines of four instructions.
// Hits are served combinationally; a miss fetches a whole 128-bit block from
// instruction memory, fills the line, and the lookup is retried in IDLE.

module i_cache #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INDEX_BITS        = 3
) (
  input  logic             clock,
  input  logic             reset,
  i_cache_fetch_if.slave   fetch,
  i_cache_mem_if.master    mem
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDRESS_WIDTH - 4 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, FILL} state_t;
  typedef logic [3:0][INSTRUCTION_WIDTH-1:0] line_t;

  state_t state_q, state_d;

  // Line storage
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  line_t               data_q [LINES];

  // Miss handling
  logic                     mem_read_q;
  logic [ADDRESS_WIDTH-5:0] mem_address_q;
  logic                     req_seen_q;
  line_t                    fill_data_q;

  // Address fields of the current fetch
  logic [1:0]            pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  pc_unused;

  logic                  hit;
  logic                  miss_start;
  logic                  mem_done;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  logic [INSTRUCTION_WIDTH-1:0] instruction_d;
  logic                         cpu_busywait_d;

  assign pc_word   = fetch.pc[3:2];
  assign pc_index  = fetch.pc[3+INDEX_BITS:4];
  assign pc_tag    = fetch.pc[ADDRESS_WIDTH-1:4+INDEX_BITS];
  assign pc_unused = ^fetch.pc[1:0];

  assign hit        = fetch.cpu_read && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign miss_start = (state_q == IDLE) && fetch.cpu_read && !hit;
  // The first MEM_READ edge only arms req_seen, so a completion is never
  // taken from the cycle the request was issued in.
  assign mem_done   = (state_q == MEM_READ) && req_seen_q && !mem.mem_busywait;
  assign fill_index = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag   = mem_address_q[ADDRESS_WIDTH-5:INDEX_BITS];

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps latches from being inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (miss_start) state_d = MEM_READ;
      MEM_READ: if (mem_done)   state_d = FILL;
      FILL:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Fetch-side outputs: hit data and stall
  always_comb begin
    instruction_d  = '0;
    cpu_busywait_d = fetch.cpu_read && !((state_q == IDLE) && hit);
    if ((state_q == IDLE) && hit) instruction_d = data_q[pc_index][pc_word];
  end

  // Memory request registers: address latched at the miss, read held until completion
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      req_seen_q    <= 1'b0;
    end else begin
      req_seen_q <= (state_q == MEM_READ) && !mem_done;
      if (miss_start) begin
        mem_read_q    <= 1'b1;
        mem_address_q <= fetch.pc[ADDRESS_WIDTH-1:4];
      end else if (mem_done) begin
        mem_read_q <= 1'b0;
      end
    end
  end

  // Valid bits: flush beats a coincident fill
  always_ff @(posedge clock) begin
    if (!reset)                  valid_q <= '0;
    else if (fetch.flush)        valid_q <= '0;
    else if (state_q == FILL)    valid_q[fill_index] <= 1'b1;
  end

  // Tag/data arrays and the fill buffer
  always_ff @(posedge clock) begin
    // NOTE: tag and data arrays are not reset; valid bits alone decide whether
    // their contents are meaningful.
    if (mem_done) fill_data_q <= mem.mem_readdata;
    if (reset && (state_q == FILL)) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data_q;
    end
  end

  assign fetch.instruction  = instruction_d;
  assign fetch.cpu_busywait = cpu_busywait_d;
  assign mem.mem_read       = mem_read_q;
  assign mem.mem_address    = mem_address_q;

endmodule

// File: tb/tb_i_cache.sv
// Randomized self-checking bench for i_cache with a line-level reference
// model (valid/tag per index) and a behavioural block memory.

module tb_i_cache;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  i_cache_fetch_if #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(32)) fif ();
  i_cache_mem_if   #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(32)) mif ();

  i_cache #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .fetch (fif),
    .mem   (mif)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;
  int req_count     = 0;

  // Reference model: which block each index currently holds
  bit          valid_m [8];
  logic [24:0] tag_m   [8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory image: fixed words at the start, a hash elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h00:  return 32'h00040019;
      32'h04:  return 32'h00050023;
      32'h08:  return 32'h02060405;
      32'h0C:  return 32'h0001005A;
      32'h10:  return 32'h03010104;
      default: return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  function automatic logic [127:0] block_data(input logic [27:0] blk);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = mem_word({blk, 4'h0} + 32'(4 * k));
    return d;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
  endfunction

  // Block memory: busywait rises with mem_read, drops at a falling edge after
  // a random latency, aborts if the request is withdrawn by reset.
  initial begin
    logic [27:0] blk;
    int          lat;
    bit          aborted;
    mif.mem_busywait = 1'b0;
    mif.mem_readdata = '0;
    forever begin
      @(posedge mif.mem_read);
      mif.mem_busywait = 1'b1;
      req_count++;
      #1 blk = mif.mem_address;
      lat = $urandom_range(1, 4);
      aborted = 1'b0;
      for (int i = 0; i < lat; i++) begin
        @(negedge clock);
        if (!mif.mem_read) begin
          aborted = 1'b1;
          break;
        end
      end
      mif.mem_readdata = aborted ? '0 : block_data(blk);
      mif.mem_busywait = 1'b0;
      while (mif.mem_read) @(negedge clock);
    end
  end

  // One fetch; the caller is just after a rising edge. Optionally pulses
  // flush so that it lands on the FILL edge of the miss.
  task automatic fetch(input logic [31:0] a, input bit flush_fill);
    bit exp_hit, prev_mr, flushed;
    int reqs0, n;
    logic [2:0] idx;
    idx     = a[6:4];
    exp_hit = valid_m[idx] && (tag_m[idx] == a[31:7]);
    fif.pc       = a;
    fif.cpu_read = 1'b1;
    reqs0        = req_count;
    @(negedge clock);
    check("busywait_req", fif.cpu_busywait, !exp_hit);
    if (!exp_hit) begin
      check("instr_stall", fif.instruction, 32'h0);
      @(negedge clock);
      check("mem_read_set", mif.mem_read, 1'b1);
      check("mem_address", mif.mem_address, a[31:4]);
      prev_mr = 1'b1;
      flushed = 1'b0;
      n = 0;
      while (fif.cpu_busywait && n < 80) begin
        if (fif.flush) fif.flush = 1'b0;
        if (flush_fill && !flushed && prev_mr && !mif.mem_read) begin
          fif.flush = 1'b1;
          flushed   = 1'b1;
        end
        prev_mr = mif.mem_read;
        @(negedge clock);
        n++;
      end
      fif.flush = 1'b0;
      check("miss_done", fif.cpu_busywait, 1'b0);
      check("req_count", 32'(req_count - reqs0), flush_fill ? 32'd2 : 32'd1);
      if (flush_fill) model_clear();
    end
    check("instruction", fif.instruction, mem_word(a));
    check("mem_read_idle", mif.mem_read, 1'b0);
    valid_m[idx] = 1'b1;
    tag_m[idx]   = a[31:7];
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush();
    fif.cpu_read = 1'b0;
    fif.flush    = 1'b1;
    @(posedge clock);
    #1 fif.flush = 1'b0;
    model_clear();
  endtask

  task automatic idle_cycle();
    fif.cpu_read = 1'b0;
    @(negedge clock);
    check("idle_busywait", fif.cpu_busywait, 1'b0);
    check("idle_instr", fif.instruction, 32'h0);
    @(posedge clock);
    #1;
  endtask

  // Overall time bound
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [24:0] tags [4];
    int          n;
    tags[0] = 25'h0; tags[1] = 25'h1; tags[2] = 25'h2; tags[3] = 25'h1FFFFFF;

    reset        = 1'b0;
    fif.cpu_read = 1'b0;
    fif.pc       = '0;
    fif.flush    = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_read", mif.mem_read, 1'b0);
    check("rst_mem_address", mif.mem_address, 28'h0);
    check("rst_instr", fif.instruction, 32'h0);
    check("rst_busywait_idle", fif.cpu_busywait, 1'b0);
    fif.cpu_read = 1'b1;
    #1 check("rst_busywait_read", fif.cpu_busywait, 1'b1);
    reset = 1'b1;

    // Directed sequence
    fetch(32'h0, 0);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    fetch(32'hC, 0);
    fetch(32'h10, 0);
    fetch(32'h0, 0);
    fetch(32'h80, 0);
    fetch(32'h0, 0);
    fetch(32'h10, 0);
    do_flush();
    fetch(32'h0, 0);
    fetch(32'h14, 0);
    fetch(32'h8, 1);
    fetch(32'h4, 0);
    fetch(32'h10, 0);

    // Reset in the middle of a miss
    fif.pc       = 32'h20;
    fif.cpu_read = 1'b1;
    n = 0;
    while (!mif.mem_read && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("midmiss_mem_read", mif.mem_read, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midmiss_rst_mem_read", mif.mem_read, 1'b0);
    check("midmiss_rst_addr", mif.mem_address, 28'h0);
    check("midmiss_rst_busywait", fif.cpu_busywait, 1'b1);
    check("midmiss_rst_instr", fif.instruction, 32'h0);
    reset = 1'b1;
    model_clear();
    fetch(32'h20, 0);
    fetch(32'h10, 0);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 19);
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      if (r == 0)      do_flush();
      else if (r == 1) idle_cycle();
      else if (r == 2 && !(valid_m[a[6:4]] && tag_m[a[6:4]] == a[31:7])) fetch(a, 1);
      else             fetch(a, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/i_cache.md
# i_cache

Direct-mapped instruction cache between the fetch stage and the block-wide instruction memory. It serves 32-bit instruction fetches from an 8-line, 4-instruction-per-line array. On a miss it initiates a 128-bit block read on the instruction-memory read/busywait interface, then fills the line. It stalls fetch through `cpu_busywait` until the requested instruction can be delivered from a valid line.

## Interface
- `INSTRUCTION_WIDTH`, 32, instruction width in bits; a line holds 4 instructions.
- `ADDRESS_WIDTH`, 32, byte-address width of `pc`.
- `INDEX_BITS`, 3, line-index width; 2^INDEX_BITS lines.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clock`; `reset`==0 resets the block.
- `cpu_read` input 1: fetch request, level-held until `cpu_busywait` is low.
- `pc` input ADDRESS_WIDTH: byte address of the fetch. `pc[1:0]` is ignored. `pc[3:2]` selects the word, `pc[3+INDEX_BITS:4]` selects the index, and the upper bits are the tag (25 bits at defaults).
- `flush` input 1: one-cycle pulse; invalidates all lines.
- `instruction` output INSTRUCTION_WIDTH: the selected word on a hit, 0 otherwise.
- `cpu_busywait` output 1: stall to fetch.
- `mem_read` output 1: block read request to memory, registered.
- `mem_address` output ADDRESS_WIDTH-4: block address, equal to `pc[ADDRESS_WIDTH-1:4]` latched at the miss. Registered.
- `mem_readdata` input 4*INSTRUCTION_WIDTH: line data; byte 0 of the block is in bits [7:0], instruction k is in bits [32k+31:32k].
- `mem_busywait` input 1: memory busy. It rises in the same timestep as `mem_read` and falls at a `clock` edge once `mem_readdata` is complete.

## Operation
- Storage: per line, one valid bit, a tag, and 128 data bits.
- `hit` = `cpu_read` & valid[index] & (tag[index] == `pc` tag). Evaluated combinationally.
- `cpu_busywait` = `cpu_read` & !(state==IDLE & `hit`). It is combinational, so it is low in the same cycle as a hit.
- `instruction` = data[index] word `pc[3:2]` when state==IDLE & `hit`, else 0.
- FSM states:
  - IDLE: if `cpu_read` & !`hit`, latch `pc[ADDRESS_WIDTH-1:4]` into `mem_address`, set `mem_read`=1, go to MEM_READ.
  - MEM_READ: hold `mem_read` and `mem_address`. A `req_seen` flag is set at the first edge in MEM_READ. At an edge with `req_seen`=1 and `mem_busywait`=0, capture `mem_readdata`, clear `mem_read`, go to FILL.
  - FILL: write data, tag, and valid=1 into line `mem_address[INDEX_BITS-1:0]`, go to IDLE. The lookup in IDLE then re-evaluates against the current `pc`.
- `flush` is honored in any state and clears every valid bit at that edge. If `flush` coincides with the FILL write, flush wins and the line stays invalid. An in-progress miss continues.
- `pc` changes while in MEM_READ do not alter `mem_address`.
- `cpu_read`=0 while in MEM_READ does not abort the memory read; the line is still filled.

## Timing
- Reset (edge with `reset`=0) results: state=IDLE, all valid=0, `mem_read`=0, `mem_address`=0, `req_seen`=0, `instruction`=0. `cpu_busywait` equals `cpu_read`, because every access misses.
- Reset mid-miss: `mem_read` drops at that edge, no line is written, and the block returns to IDLE.
- Hit latency: 0 cycles, with the instruction valid combinationally in the request cycle.
- Miss penalty: 1 edge (IDLE→MEM_READ), plus memory wait edges (≥1), plus 1 edge (MEM_READ→FILL), plus 1 edge (FILL→IDLE). The hit then completes in the IDLE cycle.
- `mem_read` is high from the IDLE→MEM_READ edge to the MEM_READ→FILL edge, with no gaps. It is never re-asserted in FILL.
- Only one outstanding memory request is allowed.

## Test plan
- Reset, then `cpu_read`=1, `pc`=0x0 → `cpu_busywait`=1, `mem_read`=1, `mem_address`=0. After memory completes and FILL, `instruction`=0x00040019 and `cpu_busywait`=0.
- Following that, `pc`=0x4, 0x8, then 0xC on consecutive cycles → hits with no stall, giving 0x00050023, 0x02060405, then 0x0001005A. `mem_read` stays 0.
- `pc`=0x10 → miss with `mem_address`=1, fills line 1, `instruction`=0x03010104. Then `pc`=0x0 → hit (line 0 intact).
- Conflict: `pc`=0x80 (same index 0, different tag) → miss and refill of line 0. Then `pc`=0x0 → miss again.
- `flush` pulse after lines 0 and 1 are valid → the next `pc`=0x0 misses. `flush` asserted on the FILL edge → the line is not valid and the following access misses.
- `reset`=0 asserted during MEM_READ → `mem_read`=0 at that edge, state IDLE, and the same `pc` re-misses after reset is released.
